// File: rtl/pyr_expand.sv
// Streaming 2x pyramid upsampler: each half-res pixel doubled horizontally, each row replayed from a row buffer.
// Optional build macro PYR_EXPAND_INTERP_EN selects beat-local linear interpolation instead of pixel replication.
module pyr_expand #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8*PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] in_frame,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] out_frame,
  output logic                  out_valid,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int IN_COLS = IMAGE_DIM/(2*PIXELS_PER_BEAT);
  localparam int H       = PIXELS_PER_BEAT/2;
  localparam int COL_W   = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int ROW_W   = $clog2(IMAGE_DIM);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_COLS-1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_DIM-1);

  typedef enum logic {FILL, REPLAY} phase_t;

`ifdef PYR_EXPAND_INTERP_EN
  function automatic logic [7:0] avg_rnd(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(sum >> 1);
  endfunction
`endif

  function automatic logic [DATA_WIDTH-1:0] expand(input logic [DATA_WIDTH-1:0] s,
                                                   input logic h);
    logic [DATA_WIDTH-1:0] r;
    logic [7:0]            a;
    int                    j;
`ifdef PYR_EXPAND_INTERP_EN
    int                    jn;
`endif
    r = '0;
    for (int k = 0; k < H; k++) begin
      j = (h ? H : 0) + k;
      a = s[8*j +: 8];
      r[16*k +: 8] = a;
`ifdef PYR_EXPAND_INTERP_EN
      // The right neighbour of the last pixel in a beat is the pixel itself.
      jn = (j == PIXELS_PER_BEAT-1) ? j : j + 1;
      r[16*k+8 +: 8] = avg_rnd(a, s[8*jn +: 8]);
`else
      r[16*k+8 +: 8] = a;
`endif
    end
    return r;
  endfunction

  phase_t                phase;
  logic                  half;
  logic [COL_W-1:0]      in_col;
  logic [ROW_W-1:0]      out_row;
  logic [DATA_WIDTH-1:0] hold_p0;
  logic [DATA_WIDTH-1:0] rowbuf [IN_COLS];

  logic                  advance;
  logic                  load;
  logic                  last_col;
  logic [DATA_WIDTH-1:0] src;

  assign advance  = ~out_valid | ~stall;
  assign in_ready = (phase == FILL) & ~half & advance;
  assign last_col = (in_col == LAST_COL);

  always_comb begin
    src  = in_frame;
    load = 1'b0;
    if (phase == FILL && !half) begin
      src  = in_frame;
      load = in_valid & advance;
    end else if (phase == FILL) begin
      src  = hold_p0;
      load = advance;
    end else begin
      src  = rowbuf[in_col];
      load = advance;
    end
  end

  // Stage p0: capture accepted beat for its second half and for the row replay
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      hold_p0        <= in_frame;
      rowbuf[in_col] <= in_frame;
    end
  end

  // Output register stage and traversal counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_frame <= '0;
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
      in_col    <= '0;
      half      <= 1'b0;
      phase     <= FILL;
      out_row   <= '0;
    end else if (load) begin
      out_frame <= expand(src, half);
      out_valid <= 1'b1;
      out_eol   <= half & last_col;
      out_eof   <= half & last_col & (out_row == LAST_ROW);
      half      <= ~half;
      if (half) begin
        if (last_col) begin
          in_col <= '0;
          if (out_row == LAST_ROW) begin
            out_row <= '0;
            phase   <= FILL;
          end else begin
            out_row <= out_row + ROW_W'(1);
            phase   <= (phase == FILL) ? REPLAY : FILL;
          end
        end else begin
          in_col <= in_col + COL_W'(1);
        end
      end
    end else if (out_valid && !stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pyr_expand.sv
// Randomized scoreboard bench for pyr_expand (4 pixels per beat, 16x16 output image).
module tb_pyr_expand;

  localparam int PPB     = 4;
  localparam int DIM     = 16;
  localparam int DW      = 8*PPB;
  localparam int IN_COLS = DIM/(2*PPB);
  localparam int NBEATS  = IN_COLS*(DIM/2);

`ifdef PYR_EXPAND_INTERP_EN
  localparam bit          INTERP = 1'b1;
  localparam logic [DW-1:0] SB_IN = 32'h0A060402;
  localparam logic [DW-1:0] SB_E0 = 32'h05040302;
  localparam logic [DW-1:0] SB_E1 = 32'h0A0A0806;
`else
  localparam bit          INTERP = 1'b0;
  localparam logic [DW-1:0] SB_IN = 32'h04030201;
  localparam logic [DW-1:0] SB_E0 = 32'h02020101;
  localparam logic [DW-1:0] SB_E1 = 32'h04040303;
`endif

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] in_frame;
  logic          in_valid;
  logic          in_ready;
  logic          stall;
  logic [DW-1:0] out_frame;
  logic          out_valid;
  logic          out_eol;
  logic          out_eof;

  pyr_expand #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW)) dut (
    .clk(clk), .aresetn(aresetn), .in_frame(in_frame), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .out_frame(out_frame), .out_valid(out_valid),
    .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            eol;
    bit            eof;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] frame_in [NBEATS];
  int            acc = 0;
  int            checks = 0;
  int            errors = 0;
  int            consumed = 0;
  int            eol_seen = 0;
  int            eof_seen = 0;
  bit            stall_en = 1'b0;
  bit            abort = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: output pixel o of half h takes source pixel h*PPB/2 + o/2; odd pixels
  // optionally average with the right neighbour (clamped at the beat edge).
  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] s, input int h);
    logic [DW-1:0] r;
    int j, jn, a, b;
    r = '0;
    for (int o = 0; o < PPB; o++) begin
      j = h*(PPB/2) + o/2;
      a = int'(s[8*j +: 8]);
      if (INTERP && (o % 2 == 1)) begin
        jn = (j + 1 < PPB) ? j + 1 : j;
        b  = int'(s[8*jn +: 8]);
        a  = (a + b + 1) / 2;
      end
      r[8*o +: 8] = 8'(a);
    end
    return r;
  endfunction

  // Full-res row 2r is half-res row r expanded; row 2r+1 repeats it.
  task automatic model_accept(input logic [DW-1:0] d);
    exp_t e;
    int ir, ic;
    ir = acc / IN_COLS;
    ic = acc % IN_COLS;
    frame_in[acc] = d;
    for (int h = 0; h < 2; h++) begin
      e.d = model_beat(d, h);
      e.eol = (ic == IN_COLS-1) && (h == 1);
      e.eof = 1'b0;
      exp_q.push_back(e);
    end
    if (ic == IN_COLS-1) begin
      for (int c = 0; c < IN_COLS; c++) begin
        for (int h = 0; h < 2; h++) begin
          e.d = model_beat(frame_in[ir*IN_COLS + c], h);
          e.eol = (c == IN_COLS-1) && (h == 1);
          e.eof = e.eol && (2*ir + 1 == DIM-1);
          exp_q.push_back(e);
        end
      end
    end
    acc = (acc + 1) % NBEATS;
  endtask

  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_en ? ($urandom_range(0, 99) < 30) : 1'b0;
    end
  end

  logic [DW-1:0] held_d;
  bit            held = 1'b0;
  bit            held_eol, held_eof;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (aresetn !== 1'b1) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_hold_frame", out_frame, held_d);
        chk("stall_hold_eol", out_eol, held_eol);
        chk("stall_hold_eof", out_eof, held_eof);
      end
      if (out_valid && stall) chk("in_ready_stalled", in_ready, 1'b0);
      if (out_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat at %0t", out_frame, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_frame", out_frame, e.d);
          chk("out_eol", out_eol, e.eol);
          chk("out_eof", out_eof, e.eof);
        end
        consumed++;
        if (out_eol) eol_seen++;
        if (out_eof) eof_seen++;
      end
      held     = out_valid && stall;
      held_d   = out_frame;
      held_eol = out_eol;
      held_eof = out_eof;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    in_frame = d;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (abort) break;
      if (in_ready) begin
        model_accept(d);
        ok = 1'b1;
        break;
      end
    end
    if (!ok && !abort) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 300 cycles");
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input bit bubbles);
    logic [DW-1:0] d;
    int px;
    bit ok;
    for (int a = 0; a < NBEATS; a++) begin
      if (abort) return;
      for (int i = 0; i < PPB; i++) begin
        px = rnd ? int'($urandom_range(0, 255)) : 8*(a / IN_COLS) + (a % IN_COLS)*PPB + i;
        d[8*i +: 8] = 8'(px);
      end
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send_beat(d, ok);
      if (!ok) return;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic reset_and_check();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_frame", out_frame, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_eol", out_eol, 0);
    chk("rst_out_eof", out_eof, 0);
    exp_q.delete();
    acc = 0;
    abort = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    consumed = 0;
    eol_seen = 0;
    eof_seen = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    aresetn  = 1'b1;
    in_valid = 1'b0;
    in_frame = '0;
    #2;
    aresetn = 1'b0;
    #1;
    chk("init_out_frame", out_frame, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_eol", out_eol, 0);
    chk("init_out_eof", out_eof, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    #1;
    chk("init_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single beat against fixed expected values
    send_beat(SB_IN, ok);
    @(negedge clk);
    chk("single_valid0", out_valid, 1);
    chk("single_beat0", out_frame, SB_E0);
    @(negedge clk);
    chk("single_valid1", out_valid, 1);
    chk("single_beat1", out_frame, SB_E1);
    reset_and_check();

    // Ramp frame, no stall, with row-0 replay window check
    clear_counts();
    fork
      send_frame(1'b0, 1'b0);
      begin
        for (int t = 0; t < 500; t++) begin
          @(posedge clk);
          if (acc == IN_COLS) break;
        end
        @(negedge clk);
        repeat (2*IN_COLS) begin
          @(negedge clk);
          chk("replay_in_ready", in_ready, 0);
        end
        @(negedge clk);
        chk("post_replay_in_ready", in_ready, 1);
      end
    join
    drain();
    chk("ramp_beats", consumed, 4*NBEATS);
    chk("ramp_eol_count", eol_seen, DIM);
    chk("ramp_eof_count", eof_seen, 1);

    // Random data, random stall and input bubbles
    stall_en = 1'b1;
    clear_counts();
    send_frame(1'b1, 1'b1);
    drain();
    chk("rand_beats", consumed, 4*NBEATS);
    chk("rand_eof_count", eof_seen, 1);

    // Reset after 21 output beats, then a fresh frame
    clear_counts();
    fork
      send_frame(1'b1, 1'b0);
      begin
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 3000; t++) begin
          @(posedge clk);
          if (consumed >= 21) begin
            hit = 1'b1;
            break;
          end
        end
        chk("reach_beat21", hit, 1);
        abort = 1'b1;
      end
    join
    reset_and_check();
    clear_counts();
    send_frame(1'b1, 1'b1);
    drain();
    chk("post_reset_beats", consumed, 4*NBEATS);
    chk("post_reset_eof_count", eof_seen, 1);

    stall_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pyr_expand.md
# pyr_expand

Streaming 2x upsampler (pyramid expand) for the Laplacian fusion datapath. Consumes a half-resolution image of (IMAGE_DIM/2)x(IMAGE_DIM/2) 8-bit pixels, PIXELS_PER_BEAT per beat. Emits the full-resolution IMAGE_DIM x IMAGE_DIM image in the same beat format as the Gaussian convolution stage. Each input pixel is replicated 2x horizontally; each input row is replayed from an internal row buffer to form the second output row.

## Interface
- PIXELS_PER_BEAT, 16, pixels per beat; even.
- IMAGE_DIM, 512, output image side; IMAGE_DIM/2 is a multiple of PIXELS_PER_BEAT.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, beat width; pixel i at bits [8i+:8].
- clk  in  1  clock; all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- in_frame  in  DATA_WIDTH  half-res input beat.
- in_valid  in  1  in_frame valid.
- in_ready  out  1  block accepts in_frame this cycle.
- stall  in  1  downstream hold; output is consumed when out_valid & ~stall.
- out_frame  out  DATA_WIDTH  full-res output beat, registered.
- out_valid  out  1  out_frame valid.
- out_eol  out  1  out_frame is the last beat of an output row.
- out_eof  out  1  out_frame is the last beat of the frame.

## Operation
- Derived constants: IN_COLS = IMAGE_DIM/(2*PIXELS_PER_BEAT) input beats per row; OUT_COLS = 2*IN_COLS output beats per row; H = PIXELS_PER_BEAT/2.
- Storage: hold register (1 beat); row buffer of IN_COLS beats, combinational read, indexed by in_col.
- Counters: in_col (0..IN_COLS-1), half (0/1), phase (FILL/REPLAY), out_row (0..IMAGE_DIM-1).
- Expansion of source beat s, half h: out pixel 2k and 2k+1 = s pixel (h*H + k), for k = 0..H-1.
- "advance" = ~out_valid | ~stall (output register free or being consumed).
- FILL, half=0: in_ready = advance. On in_valid & in_ready: hold <= in_frame; rowbuf[in_col] <= in_frame; out_frame <= expand(in_frame, 0); half <= 1.
- FILL, half=1: in_ready = 0. On advance: out_frame <= expand(hold, 1); half <= 0; in_col increments.
- REPLAY: in_ready = 0. On advance: out_frame <= expand(rowbuf[in_col], half); half toggles; in_col increments after half=1.
- End of row (in_col = IN_COLS-1, half=1, beat loaded): in_col <= 0; phase toggles FILL<->REPLAY; out_row increments; wraps to 0 after IMAGE_DIM-1 with phase FILL.
- out_valid set when a beat is loaded. Cleared on consumption (out_valid & ~stall) if no new beat is loaded the same edge.
- out_eol = 1 for the beat loaded with in_col = IN_COLS-1, half=1. out_eof = out_eol & (out_row = IMAGE_DIM-1) for that beat.
- The row buffer is not cleared by reset; REPLAY only reads entries written in the preceding FILL row.

## Timing
- Reset (async assert, sync-released): out_frame=0, out_valid=0, out_eol=0, out_eof=0, in_col=0, half=0, phase=FILL, out_row=0; in_ready=1 as soon as reset deasserts.
- Latency: an input accepted at edge N yields out_frame valid from edge N (observable cycle N+1). Its second beat loads at the next advancing edge.
- Throughput: 1 output beat per cycle with stall=0. The input is accepted at most every 2nd cycle during FILL and not at all during REPLAY (1 input beat per 4 output beats averaged).
- stall=1 with out_valid=1: out_frame, out_eol, out_eof and all counters hold; in_ready=0.
- Simultaneous consumption and load on one edge: the new beat replaces the old one; out_valid stays 1.
- in_valid=0 in FILL half=0: no load; out_valid drops after the pending beat is consumed. Bubbles are allowed.
- aresetn asserted mid-frame: immediate return to reset state; the partial frame is discarded; the next accepted beat is treated as row 0, column 0.

## Configuration
- PYR_EXPAND_INTERP_EN defined: beat-local horizontal linear interpolation. out pixel 2k = s[j]; out pixel 2k+1 = (s[j] + s[j+1] + 1) >> 1, with j = h*H + k and a 9-bit intermediate. For j = PIXELS_PER_BEAT-1, s[j+1] is replaced by s[j]. Applies to both FILL and REPLAY beats.
- Undefined: pure replication as in Operation. Timing is identical in both builds.

## Test plan
Bench configuration: PIXELS_PER_BEAT=4, IMAGE_DIM=16 (IN_COLS=2, OUT_COLS=4).
- Single beat: in_frame=0x04030201, stall=0 -> consecutive out_frame values 0x02020101, then 0x04040303.
- Full frame of 16 input beats, ramp pixel value = 8*row + col, stall=0 -> 64 output beats. Each output row r equals half-res row r>>1 with pixels doubled. out_eol on every 4th beat; out_eof only on beat 64.
- Row replay: after input row 0 completes -> in_ready=0 for 4 cycles and the replayed beats match the FILL row exactly.
- Random stall with ~30% duty -> out_frame held stable while stall=1. No beat lost or duplicated against the reference model. in_ready=0 whenever out_valid & stall.
- Reset at output beat 21 -> outputs 0 immediately; a fresh frame then matches the model from beat 0.
- PYR_EXPAND_INTERP_EN build: in_frame=0x0A060402 -> out_frame 0x05040302, then 0x0A0A0806.
